md_unit: RTL and testbench

Multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It consumes the forwarded rs/rt operands read out of the register file, executes mult/multu/div/divu over several cycles, and holds the HI/LO pair. mthi/mtlo write HI/LO directly; mfhi/mflo read them back through `md_result` toward the write-back path. `md_busy` feeds the hazard unit, which stalls any multiply/divide-class instruction in D.

---
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit.sv | 123 ++++++++++++
 tb/tb_md_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage multiply/divide unit port bundle
interface md_unit_if;
   logic        md_start;
   logic [2:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_read_hi;
   logic        md_busy;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic [31:0] md_result;

   // Pipeline side: issues operations and reads HI/LO back
   modport master (
      output md_start, md_op, md_a, md_b, md_read_hi,
      input  md_busy, md_hi, md_lo, md_result
   );

   // Unit side
   modport slave (
      input  md_start, md_op, md_a, md_b, md_read_hi,
      output md_busy, md_hi, md_lo, md_result
   );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit holding the HI/LO pair
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [2:0]       op_q;
   logic [31:0]      a_q;
   logic [31:0]      b_q;

   logic             launch;
   logic             a_neg;
   logic             b_neg;
   logic [31:0]      a_mag;
   logic [31:0]      b_mag;
   logic [31:0]      q_mag;
   logic [31:0]      r_mag;
   logic [63:0]      mul_a;
   logic [63:0]      mul_b;
   logic [63:0]      product;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_wr;

   assign launch = md.md_start && (md.md_op inside {[OP_MULT:OP_DIVU]});

   // Result from the latched operands; signed divide works on magnitudes so
   // 0x80000000 / -1 needs no overflow special case
   always_comb begin
      a_neg   = (op_q == OP_DIV) && a_q[31];
      b_neg   = (op_q == OP_DIV) && b_q[31];
      a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
      b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
      q_mag   = '0;
      r_mag   = '0;
      if (b_q != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      mul_a   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      mul_b   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      product = mul_a * mul_b;
      res_hi  = product[63:32];
      res_lo  = product[31:0];
      res_wr  = 1'b1;
      if (op_q == OP_DIV || op_q == OP_DIVU) begin
         res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
         res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
         res_wr = (b_q != 32'd0);
      end
   end

   // Control FSM: launch/count-down, HI/LO commit and mthi/mtlo writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  op_q   <= md.md_op;
                  a_q    <= md.md_a;
                  b_q    <= md.md_b;
                  count  <= (md.md_op == OP_MULT || md.md_op == OP_MULTU) ?
                            CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else if (md.md_op == OP_MTHI) begin
                  hi_q <= md.md_a;
               end else if (md.md_op == OP_MTLO) begin
                  lo_q <= md.md_a;
               end
            end
            RUN: begin
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
                  if (res_wr) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign md.md_busy   = busy_q;
   assign md.md_hi     = hi_q;
   assign md.md_lo     = lo_q;
   assign md.md_result = md.md_read_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic clk;
   logic reset;
   md_unit_if m ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (m)
   );

   exp_t sb[$];
   int   passes = 0;
   int   total  = 0;
   int   busy_len = 0;
   logic prev_busy = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] ehi, logic [31:0] elo, int cyc, string name, bit push);
      exp_t e;
      m.md_start = 1'b1;
      m.md_op    = op;
      m.md_a     = a;
      m.md_b     = b;
      if (push) begin
         e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
         sb.push_back(e);
      end
      tick();
      m.md_start = 1'b0;
      m.md_op    = 3'd0;
      m.md_a     = 32'hCAFE0000;
      m.md_b     = 32'h0000CAFE;
   endtask

   task automatic move(logic [2:0] op, logic [31:0] a);
      m.md_op = op;
      m.md_a  = a;
      tick();
      m.md_op = 3'd0;
   endtask

   task automatic wait_idle(string name);
      for (int i = 0; i < 50 && m.md_busy; i++) tick();
      if (m.md_busy) check({name, "_timeout"}, 32'(m.md_busy), 32'd0);
      tick();
   endtask

   // Monitor: every falling edge of busy is a completion to score
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_len  = 0;
            prev_busy = 1'b0;
         end else begin
            if (m.md_busy) busy_len++;
            else if (prev_busy) begin
               if (sb.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
               else begin
                  exp_t e;
                  e = sb.pop_front();
                  check({e.name, "_hi"}, m.md_hi, e.hi);
                  check({e.name, "_lo"}, m.md_lo, e.lo);
                  check({e.name, "_busy_cycles"}, 32'(busy_len), 32'(e.cycles));
               end
               busy_len = 0;
            end
            prev_busy = m.md_busy;
         end
      end
   end

   initial begin
      reset = 1'b1;
      m.md_start = 1'b0; m.md_op = 3'd0; m.md_a = '0; m.md_b = '0; m.md_read_hi = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_busy", 32'(m.md_busy), 32'd0);
      check("rst_hi", m.md_hi, 32'd0);
      check("rst_lo", m.md_lo, 32'd0);

      // asynchronous reset mid-cycle
      move(3'd5, 32'hDEADBEEF);
      move(3'd6, 32'hDEADBEEF);
      check("pre_hi", m.md_hi, 32'hDEADBEEF);
      check("pre_lo", m.md_lo, 32'hDEADBEEF);
      #2 reset = 1'b1;
      #1;
      check("async_rst_hi", m.md_hi, 32'd0);
      check("async_rst_lo", m.md_lo, 32'd0);
      check("async_rst_busy", 32'(m.md_busy), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      issue(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult_neg", 1'b1);
      wait_idle("mult_neg");
      m.md_read_hi = 1'b0; #1;
      check("mflo", m.md_result, 32'hFFFFFFFA);
      m.md_read_hi = 1'b1; #1;
      check("mfhi", m.md_result, 32'hFFFFFFFF);
      m.md_read_hi = 1'b0;

      issue(3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, "multu", 1'b1);
      wait_idle("multu");
      issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5, "mult_minmin", 1'b1);
      wait_idle("mult_minmin");
      issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg", 1'b1);
      wait_idle("div_neg");
      issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu", 1'b1);
      wait_idle("divu");
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf", 1'b1);
      wait_idle("div_ovf");

      // divide by zero keeps HI/LO
      move(3'd5, 32'h11111111);
      move(3'd6, 32'h22222222);
      issue(3'd3, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 10, "div_zero", 1'b1);
      wait_idle("div_zero");

      // mthi while idle, then ignored mtlo / start while running
      move(3'd5, 32'h12345678);
      check("mthi_hi", m.md_hi, 32'h12345678);
      check("mthi_busy", 32'(m.md_busy), 32'd0);
      issue(3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5, "run_ignore", 1'b1);
      move(3'd6, 32'hAAAAAAAA);
      m.md_start = 1'b1;
      move(3'd1, 32'h00000003);
      m.md_start = 1'b0;
      wait_idle("run_ignore");
      check("no_relaunch_busy", 32'(m.md_busy), 32'd0);

      // reset during busy cycle 3 of a div, then a clean mult
      issue(3'd4, 32'd100, 32'd7, 32'd0, 32'd0, 10, "div_abort", 1'b0);
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(m.md_busy), 32'd0);
      check("abort_hi", m.md_hi, 32'd0);
      check("abort_lo", m.md_lo, 32'd0);
      tick();
      reset = 1'b0;
      issue(3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5, "post_rst_mult", 1'b1);
      wait_idle("post_rst_mult");

      tick(); tick();
      if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
